led_blink_sequencer: RTL and testbench

// - Consumer end of the button one-shot path: takes a 1-cycle event pulse and renders it as N visible LED

---
 rtl/led_blink_sequencer_if.sv | 32 +++
 rtl/led_blink_sequencer.sv | 173 +++++++++++++++++
 tb/tb_led_blink_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_blink_sequencer_if.sv
// ============================================================================
//  Module   : led_blink_sequencer_if
//  Purpose  : Request/status bundle between a trigger source and the LED
//             blink sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_blink_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             iTrig;
    logic [CNT_W-1:0] iCount;
    logic             oLED;
    logic             oBusy;
    logic             oDone;
    logic             oDrop;

    // Request side: issues triggers, observes LED and status pulses
    modport master (
        output iTrig, iCount,
        input  oLED, oBusy, oDone, oDrop
    );

    // Sequencer side
    modport slave (
        input  iTrig, iCount,
        output oLED, oBusy, oDone, oDrop
    );
endinterface

`default_nettype wire

// File: rtl/led_blink_sequencer.sv
// ============================================================================
//  Module   : led_blink_sequencer
//  Purpose  : Turns a 1-cycle trigger pulse into iCount visible LED blinks
//             (ON_CYCLES lit, OFF_CYCLES dark each), then pulses oDone.
//             Optional macro PENDING_QUEUE_EN: triggers arriving while busy
//             are queued (up to MAX_PEND) and replayed back-to-back instead
//             of being dropped.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_blink_sequencer #(
    parameter int ON_CYCLES  = 1350000,
    parameter int OFF_CYCLES = 1350000,
    parameter int CNT_W      = 4,
    parameter int MAX_PEND   = 3
) (
    input  wire logic              CLK,
    input  wire logic              RESET,
    led_blink_sequencer_if.slave   bus
);

    localparam int C_MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    // Keep at least one timer bit so 1-cycle phases still elaborate
    localparam int TMR_W     = (C_MAX_CYC > 1) ? $clog2(C_MAX_CYC) : 1;
    localparam logic [TMR_W-1:0] C_ON_LAST  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] C_OFF_LAST = TMR_W'(OFF_CYCLES - 1);

`ifdef PENDING_QUEUE_EN
    localparam int PEND_W = (MAX_PEND > 0) ? $clog2(MAX_PEND + 1) : 1;
    localparam logic [PEND_W-1:0] C_MAX_PEND = PEND_W'(MAX_PEND);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               led_q, busy_q, done_q, drop_q;
    logic               done_d, drop_d;

`ifdef PENDING_QUEUE_EN
    logic [PEND_W-1:0]  pending_q, pending_d;
    logic [CNT_W-1:0]   pend_count_q, pend_count_d;
`endif

    // A trigger asking for zero blinks is ignored everywhere
    logic w_trig_ok;
    // Final OFF cycle of the last blink: the only busy cycle where a new
    // trigger chains on directly instead of being queued/dropped
    logic w_eos;

    assign w_trig_ok = bus.iTrig && (bus.iCount != '0);
    assign w_eos     = (state_q == ST_OFF) && (timer_q == C_OFF_LAST) &&
                       (remaining_q == '0);

    // Next-state, timer, blink count and status-pulse decisions
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + TMR_W'(1);
        remaining_d = remaining_q;
        done_d      = 1'b0;
        drop_d      = 1'b0;
`ifdef PENDING_QUEUE_EN
        pending_d    = pending_q;
        pend_count_d = pend_count_q;
`endif

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (w_trig_ok) begin
                    remaining_d = bus.iCount;
                    state_d     = ST_ON;
                end
            end
            ST_ON: begin
                if (timer_q == C_ON_LAST) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    timer_d     = '0;
                    state_d     = ST_OFF;
                end
            end
            ST_OFF: begin
                if (timer_q == C_OFF_LAST) begin
                    timer_d = '0;
                    if (remaining_q != '0) begin
                        state_d = ST_ON;
                    end
`ifdef PENDING_QUEUE_EN
                    else if (pending_q != '0) begin
                        // Replay the queued request; a same-cycle trigger
                        // takes the slot just freed
                        remaining_d = pend_count_q;
                        state_d     = ST_ON;
                        if (w_trig_ok) begin
                            pend_count_d = bus.iCount;
                        end else begin
                            pending_d = pending_q - PEND_W'(1);
                        end
                    end
`endif
                    else if (w_trig_ok) begin
                        remaining_d = bus.iCount;
                        state_d     = ST_ON;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        // Triggers arriving mid-sequence
        if ((state_q != ST_IDLE) && !w_eos && w_trig_ok) begin
`ifdef PENDING_QUEUE_EN
            if (pending_q == C_MAX_PEND) begin
                drop_d = 1'b1;
            end else begin
                pending_d    = pending_q + PEND_W'(1);
                pend_count_d = bus.iCount;
            end
`else
            drop_d = 1'b1;
`endif
        end
    end

    // State register and registered outputs; reset overrides everything
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            remaining_q <= '0;
            led_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
`ifdef PENDING_QUEUE_EN
            pending_q    <= '0;
            pend_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            led_q       <= (state_d == ST_ON);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= done_d;
            drop_q      <= drop_d;
`ifdef PENDING_QUEUE_EN
            pending_q    <= pending_d;
            pend_count_q <= pend_count_d;
`endif
        end
    end

    assign bus.oLED  = led_q;
    assign bus.oBusy = busy_q;
    assign bus.oDone = done_q;
    assign bus.oDrop = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_led_blink_sequencer.sv
// ============================================================================
//  Module   : tb_led_blink_sequencer
//  Purpose  : Directed stimulus for led_blink_sequencer with a timeline model
//             (runs described by start cycle and total blink count) checked
//             every cycle, plus literal spot checks at known cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_blink_sequencer;

    localparam int ON_CYCLES  = 4;
    localparam int OFF_CYCLES = 3;
    localparam int CNT_W      = 4;
    localparam int MAX_PEND   = 3;
    localparam int PERIOD     = ON_CYCLES + OFF_CYCLES;

    logic CLK;
    logic RESET;

    led_blink_sequencer_if #(.CNT_W(CNT_W)) bus ();

    led_blink_sequencer #(
        .ON_CYCLES (ON_CYCLES),
        .OFF_CYCLES(OFF_CYCLES),
        .CNT_W     (CNT_W),
        .MAX_PEND  (MAX_PEND)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_err  = 0;

`ifdef PENDING_QUEUE_EN
    localparam bit QUEUE_EN = 1'b1;
`else
    localparam bit QUEUE_EN = 1'b0;
`endif

    // ---------------- timeline model ----------------
    int  now       = 0;
    bit  m_valid   = 1'b0;
    bit  m_active  = 1'b0;
    int  m_start   = 0;     // first ON cycle of current run
    int  m_n       = 0;     // total blinks chained into current run
    int  m_pend    = 0;
    int  m_pcnt    = 0;
    bit  exp_led, exp_busy, exp_done, exp_drop;

    initial begin
        forever begin
            @(posedge CLK);
            now = now + 1;
            begin
                bit nd, ndrop, tok;
                int cnt;
                nd    = 1'b0;
                ndrop = 1'b0;
                cnt   = int'(bus.iCount);
                tok   = (bus.iTrig === 1'b1) && (cnt != 0);
                if (RESET === 1'b1) begin
                    m_active = 1'b0;
                    m_pend   = 0;
                    m_pcnt   = 0;
                    m_n      = 0;
                end else begin
                    if (!m_active) begin
                        if (tok) begin
                            m_active = 1'b1;
                            m_start  = now + 1;
                            m_n      = cnt;
                        end
                    end else if (now == m_start + m_n * PERIOD - 1) begin
                        if (m_pend > 0) begin
                            m_n = m_n + m_pcnt;
                            if (tok) m_pcnt = cnt;
                            else     m_pend = m_pend - 1;
                        end else if (tok) begin
                            m_n = m_n + cnt;
                        end else begin
                            m_active = 1'b0;
                            nd       = 1'b1;
                        end
                    end else if (tok) begin
                        if (QUEUE_EN && m_pend < MAX_PEND) begin
                            m_pend = m_pend + 1;
                            m_pcnt = cnt;
                        end else begin
                            ndrop = 1'b1;
                        end
                    end
                end
                exp_busy = m_active;
                exp_led  = m_active && (((now + 1 - m_start) % PERIOD) < ON_CYCLES);
                exp_done = nd;
                exp_drop = ndrop;
                m_valid  = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge CLK);
            if (m_valid) begin
                n_vec = n_vec + 1;
                if (bus.oLED !== exp_led || bus.oBusy !== exp_busy ||
                    bus.oDone !== exp_done || bus.oDrop !== exp_drop) begin
                    n_err = n_err + 1;
                    $display("FAIL model cyc=%0d got led/busy/done/drop=%b%b%b%b want %b%b%b%b",
                             now, bus.oLED, bus.oBusy, bus.oDone, bus.oDrop,
                             exp_led, exp_busy, exp_done, exp_drop);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Trigger during the current cycle; returns one cycle later
    task automatic trig(input int cnt);
        bus.iTrig  = 1'b1;
        bus.iCount = CNT_W'(cnt);
        wait_cycles(1);
        bus.iTrig  = 1'b0;
        bus.iCount = '0;
    endtask

    task automatic lit(input string name, input logic act, input logic req);
        n_vec = n_vec + 1;
        if (act !== req) begin
            n_err = n_err + 1;
            $display("FAIL %s got %b want %b", name, act, req);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        RESET      = 1'b1;
        bus.iTrig  = 1'b0;
        bus.iCount = '0;
        wait_cycles(5);
        lit("reset_led",  bus.oLED,  1'b0);
        lit("reset_busy", bus.oBusy, 1'b0);
        lit("reset_done", bus.oDone, 1'b0);
        lit("reset_drop", bus.oDrop, 1'b0);
        RESET = 1'b0;
        wait_cycles(3);

        // Two blinks: lit t+1..4, dark t+5..7, done at t+15
        trig(2);                                  // now t+1
        lit("t1_led_on",   bus.oLED,  1'b1);
        lit("t1_busy_on",  bus.oBusy, 1'b1);
        wait_cycles(4);                           // t+5
        lit("t1_led_off",  bus.oLED,  1'b0);
        lit("t1_busy_off", bus.oBusy, 1'b1);
        wait_cycles(3);                           // t+8
        lit("t1_led_2nd",  bus.oLED,  1'b1);
        wait_cycles(6);                           // t+14
        lit("t1_done_early", bus.oDone, 1'b0);
        wait_cycles(1);                           // t+15
        lit("t1_done",     bus.oDone, 1'b1);
        lit("t1_idle",     bus.oBusy, 1'b0);
        wait_cycles(1);
        lit("t1_done_1cyc", bus.oDone, 1'b0);
        wait_cycles(3);

        // Zero-count trigger is ignored
        trig(0);
        lit("t2_busy", bus.oBusy, 1'b0);
        wait_cycles(20);

        // Busy-time trigger: queued (3 blinks, done t+22) or dropped
        trig(1);                                  // t+1
        wait_cycles(1);                           // t+2
        trig(2);                                  // t+3
        lit("t3_drop", bus.oDrop, !QUEUE_EN);
        wait_cycles(5);                           // t+8
        lit("t3_t8_done", bus.oDone, !QUEUE_EN);
        lit("t3_t8_led",  bus.oLED,  QUEUE_EN);
        wait_cycles(14);                          // t+22
        lit("t3_t22_done", bus.oDone, QUEUE_EN);
        wait_cycles(5);

        // Queue saturation: 4 busy triggers, 4th dropped
        trig(1);                                  // t+1
        trig(1); trig(1); trig(1);                // t+4
        lit("t4_no_drop_3rd", bus.oDrop, !QUEUE_EN);
        trig(1);                                  // t+5
        lit("t4_drop_4th", bus.oDrop, 1'b1);
        wait_cycles(24);                          // t+29
        lit("t4_done", bus.oDone, QUEUE_EN);
        wait_cycles(5);

        // Reset mid-run
        trig(2);                                  // t+1
        wait_cycles(1);                           // t+2
        RESET = 1'b1;
        wait_cycles(1);                           // t+3
        RESET = 1'b0;
        lit("t5_led",  bus.oLED,  1'b0);
        lit("t5_busy", bus.oBusy, 1'b0);
        wait_cycles(15);

        // Trigger on final OFF cycle chains with no gap and no oDone
        trig(1);                                  // t+1
        wait_cycles(6);                           // t+7
        trig(1);                                  // t+8
        lit("t6_led",  bus.oLED,  1'b1);
        lit("t6_done", bus.oDone, 1'b0);
        wait_cycles(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
